sobel_stream_filter: RTL and testbench

//  Streaming 3x3 Sobel edge filter with valid/ready on both sides. Two line buffers replace the full-frame store.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_line_buffer.sv | 24 ++
 rtl/sobel_stream_filter.sv | 157 +++++++++++++++
 tb/tb_sobel_stream_filter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared encodings and width helpers for the streaming Sobel filter.
package sobel_pkg;

   typedef enum logic [1:0] {
      MODE_L1  = 2'd0,
      MODE_GX  = 2'd1,
      MODE_GY  = 2'd2,
      MODE_THR = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Signed gradient width: 4*(2^W-1) plus a sign bit.
   function automatic int grad_width(input int width);
      return width + 3;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store: each column entry packs {line r-1, line r-2}.
module sobel_line_buffer #(
   parameter int WIDTH     = 8,
   parameter int IMG_WIDTH = 640,
   parameter int COL_W     = $clog2(IMG_WIDTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [COL_W-1:0] addr_i,
   input  logic [WIDTH-1:0] pix_i,
   output logic [WIDTH-1:0] line1_o,
   output logic [WIDTH-1:0] line2_o
);

   logic [2*WIDTH-1:0] mem_q [IMG_WIDTH];

   assign {line1_o, line2_o} = mem_q[addr_i];

   // Read-before-write: the old r-1 entry ages into the r-2 slot.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= {pix_i, line1_o};
   end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter: frame FSM, raster counters, window and 2-stage compute.
//  state   | meaning
//  S_IDLE  | waiting for start, mode/thresh latched on start
//  S_RUN   | accepting raster pixels
//  S_DRAIN | all input taken, flushing until out_last handshake
//  S_DONE  | one-cycle done pulse
module sobel_stream_filter
   import sobel_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH+3:0] thresh,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pixel_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] pixel_out,
   output logic             out_last,
   output logic             done
);

   localparam int GW = grad_width(WIDTH);
   localparam int MW = WIDTH + 4;

   state_e             state_q;
   mode_e              mode_q;
   logic [MW-1:0]      thresh_q;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [WIDTH-1:0]   win_q [3][3];
   logic               s1_valid_q, s1_last_q;
   logic               out_valid_q, out_last_q, done_q;
   logic [WIDTH-1:0]   pixel_out_q;

   logic               en, accept, col_end, last_in, win_ok;
   logic [WIDTH-1:0]   line1, line2, pix_d;
   logic signed [GW-1:0] gx, gy;
   logic [MW-1:0]      abs_gx, abs_gy, l1, sel;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = (state_q == S_RUN) && en;
   assign accept   = in_valid && in_ready;
   assign col_end  = (col_q == COL_W'(IMG_WIDTH - 1));
   assign last_in  = col_end && (row_q == ROW_W'(IMG_HEIGHT - 1));
   assign win_ok   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

   assign out_valid = out_valid_q;
   assign pixel_out = pixel_out_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

   sobel_line_buffer #(
      .WIDTH    (WIDTH),
      .IMG_WIDTH(IMG_WIDTH),
      .COL_W    (COL_W)
   ) u_line_buffer (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (col_q),
      .pix_i  (pixel_in),
      .line1_o(line1),
      .line2_o(line2)
   );

   function automatic logic signed [GW-1:0] ext(input logic [WIDTH-1:0] p);
      return GW'(p);
   endfunction

   always_comb begin
      gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
      gy = (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]))
         - (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]));
      abs_gx = MW'(gx[GW-1] ? -gx : gx);
      abs_gy = MW'(gy[GW-1] ? -gy : gy);
      l1     = abs_gx + abs_gy;
      case (mode_q)
         MODE_GX: sel = abs_gx;
         MODE_GY: sel = abs_gy;
         default: sel = l1;
      endcase
      // Threshold compares the unsaturated L1 sum.
      if (mode_q == MODE_THR) pix_d = (l1 >= thresh_q) ? '1 : '0;
      else                    pix_d = (|sel[MW-1:WIDTH]) ? '1 : sel[WIDTH-1:0];
   end

   // Window registers carry no reset; their contents only matter once win_ok.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= line2;
         win_q[1][2] <= line1;
         win_q[2][2] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= MODE_L1;
         thresh_q    <= '0;
         row_q       <= '0;
         col_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pixel_out_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (en) begin
            s1_valid_q  <= accept && win_ok;
            s1_last_q   <= accept && last_in;
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) pixel_out_q <= pix_d;
         end
         if (accept) begin
            if (col_end) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         case (state_q)
            S_IDLE: if (start) begin
               state_q  <= S_RUN;
               mode_q   <= mode_e'(mode);
               thresh_q <= thresh;
               row_q    <= '0;
               col_q    <= '0;
            end
            S_RUN:   if (accept && last_in) state_q <= S_DRAIN;
            S_DRAIN: if (out_valid_q && out_ready && out_last_q) begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter on a 5x4 frame with an independent Sobel model.
module tb_sobel_stream_filter;

   localparam int IW = 5;
   localparam int IH = 4;
   localparam int NPIX = IW * IH;
   localparam int NOUT = (IW - 2) * (IH - 2);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [11:0] thresh = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  pixel_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  pixel_out;
   logic        out_last;
   logic        done;

   int n_checks = 0;
   int n_fail = 0;
   int frame [IH][IW];

   typedef struct {
      int pix;
      bit last;
      int cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   sobel_stream_filter #(
      .WIDTH(8), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .thresh(thresh),
      .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
      .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
      .out_last(out_last), .done(done)
   );

   // Sobel at centre (r,c) written directly from neighbour offsets.
   function automatic int ref_pix(int r, int c, int m, int th);
      int gx, gy, ax, ay, v;
      gx = (frame[r-1][c+1] + 2*frame[r][c+1] + frame[r+1][c+1])
         - (frame[r-1][c-1] + 2*frame[r][c-1] + frame[r+1][c-1]);
      gy = (frame[r-1][c-1] + 2*frame[r-1][c] + frame[r-1][c+1])
         - (frame[r+1][c-1] + 2*frame[r+1][c] + frame[r+1][c+1]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      case (m)
         1: v = ax;
         2: v = ay;
         3: return (ax + ay >= th) ? 255 : 0;
         default: v = ax + ay;
      endcase
      return (v > 255) ? 255 : v;
   endfunction

   task automatic fill(input int kind);
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            case (kind)
               0: frame[r][c] = 50;
               1: frame[r][c] = (c >= 2) ? 100 : 0;
               default: frame[r][c] = (r >= 2) ? 10 : 0;
            endcase
   endtask

   task automatic run_frame(input string name, input int m, input int th,
                            input bit gaps, input bit bp, input bit glitch);
      int idx = 0, outs = 0, cyc = 0, last_hs = -10;
      bit got_done = 1'b0, hold = 1'b0;
      logic [7:0] held_pix = '0;
      logic held_last = 1'b0;
      exp_t e;
      sb.delete();
      @(negedge clk);
      start = 1'b1; mode = 2'(m); thresh = 12'(th);
      @(negedge clk);
      start = 1'b0;
      while (!got_done && cyc < 3000) begin
         start     = glitch && (cyc == 8);
         if (glitch && cyc == 8) mode = 2'd2;
         in_valid  = (idx < NPIX) && (!gaps || $urandom_range(0, 2) != 0);
         pixel_in  = 8'(frame[(idx < NPIX ? idx : 0) / IW][(idx < NPIX ? idx : 0) % IW]);
         out_ready = !bp || (cyc % 4 == 0);
         #1;
         if (hold) begin
            n_checks++;
            if (out_valid !== 1'b1 || pixel_out !== held_pix || out_last !== held_last) begin
               n_fail++;
               $display("FAIL %s hold: got v=%0b p=%0d l=%0b want v=1 p=%0d l=%0b",
                        name, out_valid, pixel_out, out_last, held_pix, held_last);
            end
         end
         if (out_valid && !out_ready) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL %s stall_in_ready: got %0b want 0", name, in_ready);
            end
         end
         hold = out_valid && !out_ready;
         held_pix = pixel_out;
         held_last = out_last;
         if (in_valid && in_ready) begin
            if (idx / IW >= 2 && idx % IW >= 2) begin
               e.pix  = ref_pix(idx / IW - 1, idx % IW - 1, m, th);
               e.last = (idx == NPIX - 1);
               e.cyc  = cyc + 2;
               sb.push_back(e);
            end
            idx++;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_output: got p=%0d want none", name, pixel_out);
            end else begin
               e = sb.pop_front();
               if (pixel_out !== 8'(e.pix) || out_last !== e.last) begin
                  n_fail++;
                  $display("FAIL %s out[%0d]: got p=%0d l=%0b want p=%0d l=%0b",
                           name, outs, pixel_out, out_last, e.pix, e.last);
               end
               if (!gaps && !bp && !glitch) begin
                  n_checks++;
                  if (cyc != e.cyc) begin
                     n_fail++;
                     $display("FAIL %s latency[%0d]: got cycle %0d want %0d", name, outs, cyc, e.cyc);
                  end
               end
            end
            outs++;
            last_hs = cyc;
         end
         if (done) begin
            n_checks++;
            got_done = 1'b1;
            if (cyc != last_hs + 1 || outs != NOUT) begin
               n_fail++;
               $display("FAIL %s done: got at cycle %0d after %0d outputs want cycle %0d after %0d",
                        name, cyc, outs, last_hs + 1, NOUT);
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (!got_done || outs != NOUT || sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s frame_end: got done=%0b outs=%0d pending=%0d want done=1 outs=%0d pending=0",
                  name, got_done, outs, sb.size(), NOUT);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, pixel_out, out_last, done} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset: got rdy=%0b v=%0b p=%0d l=%0b d=%0b want all 0",
                  in_ready, out_valid, pixel_out, out_last, done);
      end
      @(negedge clk);
   endtask

   task automatic test_flat;
      fill(0);
      run_frame("flat_l1", 0, 0, 0, 0, 0);
   endtask

   task automatic test_vedge;
      fill(1);
      run_frame("vedge_l1", 0, 0, 0, 0, 0);
      run_frame("vedge_gy", 2, 0, 0, 0, 0);
   endtask

   task automatic test_hedge;
      fill(2);
      run_frame("hedge_gy", 2, 0, 0, 0, 0);
      run_frame("hedge_gx", 1, 0, 0, 0, 0);
      run_frame("hedge_l1", 0, 0, 0, 0, 0);
   endtask

   task automatic test_thresh;
      fill(1);
      run_frame("thr_300", 3, 300, 0, 0, 0);
      run_frame("thr_401", 3, 401, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      fill(1);
      run_frame("backpressure", 0, 0, 1, 1, 0);
      run_frame("start_ignored", 0, 0, 0, 0, 1);
   endtask

   task automatic test_rst_midframe;
      int fed = 0, cyc = 0;
      fill(1);
      @(negedge clk);
      start = 1'b1; mode = 2'd0;
      @(negedge clk);
      start = 1'b0;
      while (fed < 10 && cyc < 100) begin
         in_valid = 1'b1;
         pixel_in = 8'(frame[fed / IW][fed % IW]);
         #1;
         if (in_ready) fed++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (fed != 10 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_midframe: got fed=%0d v=%0b rdy=%0b d=%0b want fed=10 v=0 rdy=0 d=0",
                  fed, out_valid, in_ready, done);
      end
      fill(0);
      run_frame("after_rst_flat", 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_flat();
      test_vedge();
      test_hedge();
      test_thresh();
      test_back_to_back();
      test_rst_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
